// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered MDU results.
// Optional starvation guard enabled by defining REGFILE_ARB_STARVE_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module regfile_wb_arbiter #(
  parameter int unsigned WORD_WIDTH = `WORD_WIDTH,
  parameter int unsigned FIFO_DEPTH = 2
`ifdef REGFILE_ARB_STARVE_EN
  ,
  parameter int unsigned MAX_WAIT = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [WORD_WIDTH-1:0] wb_data,
  input  logic                  mdu_valid,
  input  logic [4:0]            mdu_addr,
  input  logic [WORD_WIDTH-1:0] mdu_data,
  output logic                  mdu_ready,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_addr,
  input  logic [4:0]            rd_addr1,
  input  logic [4:0]            rd_addr2,
  output logic                  rd_busy,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [WORD_WIDTH-1:0] rf_wdata
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 5;
  localparam int unsigned NR = 32;

  typedef struct packed {
    logic [RW-1:0]         addr;
    logic [WORD_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [NR-1:0]   busy;
  logic [NR-1:0]   busy_nxt;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);

  // Ready depends only on registered occupancy; a pop frees a slot for the next cycle.
  assign mdu_ready = rst_n && (count != CW'(FIFO_DEPTH));
  assign push      = mdu_valid && mdu_ready;
  assign pop       = rst_n && !wb_en && !fifo_empty;

  // Write-port mux: pipeline first, FIFO head in bubbles, register 0 never written.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = head.addr;
    rf_wdata = head.data;
    if (wb_en) begin
      rf_waddr = wb_addr;
      rf_wdata = wb_data;
      rf_we    = rst_n && (wb_addr != '0);
    end else if (!fifo_empty) begin
      rf_we    = rst_n && (head.addr != '0);
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Scoreboard update: a drain clears, a new issue sets, and set takes precedence.
  always_comb begin
    busy_nxt = busy;
    if (pop) begin
      busy_nxt[head.addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      busy_nxt[issue_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      busy  <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].addr <= mdu_addr;
      mem[wr_ptr].data <= mdu_data;
    end
  end

  assign rd_busy = rst_n && (busy[rd_addr1] || busy[rd_addr2]);

`ifdef REGFILE_ARB_STARVE_EN
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt;

  // Counts cycles the FIFO head is blocked by writeback; saturates at the threshold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (pop || fifo_empty) begin
      wait_cnt <= '0;
    end else if (wb_en && (wait_cnt < WW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign stall_req = rst_n && (wait_cnt >= WW'(MAX_WAIT));
`else
  assign stall_req = 1'b0;
`endif

`ifndef SYNTHESIS
  // Pipeline contract monitors; an issue to a register retiring this same cycle is legal.
  always_ff @(posedge clk) begin
    if (rst_n && issue_valid && (issue_addr != '0) && busy[issue_addr]
        && !(pop && (head.addr == issue_addr))) begin
      $error("regfile_wb_arbiter: issue to busy register r%0d", issue_addr);
    end
    if (rst_n && wb_en && (wb_addr != '0) && busy[wb_addr]) begin
      $error("regfile_wb_arbiter: writeback to busy register r%0d", wb_addr);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  localparam int unsigned WW = 32;

  logic          clk;
  logic          rst_n;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [WW-1:0] wb_data;
  logic          mdu_valid;
  logic [4:0]    mdu_addr;
  logic [WW-1:0] mdu_data;
  logic          mdu_ready;
  logic          issue_valid;
  logic [4:0]    issue_addr;
  logic [4:0]    rd_addr1;
  logic [4:0]    rd_addr2;
  logic          rd_busy;
  logic          stall_req;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [WW-1:0] rf_wdata;

  int n_cmp;
  int n_err;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .mdu_valid   (mdu_valid),
    .mdu_addr    (mdu_addr),
    .mdu_data    (mdu_data),
    .mdu_ready   (mdu_ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd_busy     (rd_busy),
    .stall_req   (stall_req),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after posedge; outputs are checked at the following negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    mdu_valid   = 1'b0;
    mdu_addr    = '0;
    mdu_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
    tick();
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  logic exp_stall;

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rd_addr1 = '0;
    rd_addr2 = '0;

    // Reset held two cycles while the MDU offers a result
    rst_n     = 1'b0;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd5;
    mdu_data  = 32'h55;
    settle();
    check("rst_we", rf_we, 1'b0);
    check("rst_ready", mdu_ready, 1'b0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_busy", rd_busy, 1'b0);
    tick();
    settle();
    check("rst_ready2", mdu_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
    settle();
    check("post_rst_empty", rf_we, 1'b0);
    check("post_rst_ready", mdu_ready, 1'b1);
    tick();

    // Writeback bypasses a pending FIFO head
    issue(5'd9);
    rd_addr1  = 5'd9;
    wb_en     = 1'b1;
    wb_addr   = 5'd8;
    wb_data   = 32'h11;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd9;
    mdu_data  = 32'h22;
    settle();
    check("bp_ready", mdu_ready, 1'b1);
    check("bp_we0", rf_we, 1'b1);
    check("bp_busy9", rd_busy, 1'b1);
    tick();
    mdu_valid = 1'b0;
    settle();
    check("bp_wb_addr", rf_waddr, 5'd8);
    check("bp_wb_data", rf_wdata, 32'h11);
    tick();
    wb_en = 1'b0;
    settle();
    check("bp_drain_we", rf_we, 1'b1);
    check("bp_drain_addr", rf_waddr, 5'd9);
    check("bp_drain_data", rf_wdata, 32'h22);
    check("bp_busy_hold", rd_busy, 1'b1);
    tick();
    settle();
    check("bp_after_we", rf_we, 1'b0);
    check("bp_busy_clr", rd_busy, 1'b0);
    tick();
    rd_addr1 = '0;

    // FIFO fill under continuous writeback, then ordered drain
    issue(5'd11);
    issue(5'd12);
    issue(5'd13);
    wb_en     = 1'b1;
    wb_addr   = 5'd1;
    wb_data   = 32'h1;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd11;
    mdu_data  = 32'hA;
    settle();
    check("full_rdy0", mdu_ready, 1'b1);
    tick();
    mdu_addr = 5'd12;
    mdu_data = 32'hB;
    settle();
    check("full_rdy1", mdu_ready, 1'b1);
    tick();
    mdu_addr = 5'd13;
    mdu_data = 32'hC;
    settle();
    check("full_rdy_low", mdu_ready, 1'b0);
    check("full_wb_addr", rf_waddr, 5'd1);
    tick();
    wb_en = 1'b0;
    settle();
    check("full_no_popthru", mdu_ready, 1'b0);
    check("full_pop_a_addr", rf_waddr, 5'd11);
    check("full_pop_a_data", rf_wdata, 32'hA);
    tick();
    settle();
    check("full_rdy_back", mdu_ready, 1'b1);
    check("full_pop_b_data", rf_wdata, 32'hB);
    tick();
    mdu_valid = 1'b0;
    settle();
    check("full_pop_c_addr", rf_waddr, 5'd13);
    check("full_pop_c_data", rf_wdata, 32'hC);
    tick();
    settle();
    check("full_empty_we", rf_we, 1'b0);
    tick();

    // Scoreboard set/clear, with set winning over a same-cycle drain
    issue(5'd10);
    rd_addr1  = 5'd10;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd10;
    mdu_data  = 32'h77;
    settle();
    check("sb_busy_set", rd_busy, 1'b1);
    check("sb_no_same_cycle", rf_we, 1'b0);
    tick();
    mdu_valid   = 1'b0;
    issue_valid = 1'b1;
    issue_addr  = 5'd10;
    settle();
    check("sb_drain_data", rf_wdata, 32'h77);
    check("sb_busy_drain", rd_busy, 1'b1);
    tick();
    issue_valid = 1'b0;
    issue_addr  = '0;
    rd_addr1    = '0;
    rd_addr2    = 5'd10;
    settle();
    check("sb_set_wins", rd_busy, 1'b1);
    check("sb_idle_we", rf_we, 1'b0);
    mdu_valid = 1'b1;
    mdu_data  = 32'h78;
    tick();
    mdu_valid = 1'b0;
    settle();
    check("sb_drain2_data", rf_wdata, 32'h78);
    check("sb_busy_drain2", rd_busy, 1'b1);
    tick();
    settle();
    check("sb_busy_clr", rd_busy, 1'b0);
    tick();
    rd_addr2 = '0;

    // Register 0: never busy, never written, but still drained
    issue(5'd0);
    issue(5'd14);
    mdu_valid = 1'b1;
    mdu_addr  = 5'd0;
    mdu_data  = 32'hFF;
    tick();
    mdu_addr = 5'd14;
    mdu_data = 32'hEE;
    settle();
    check("z_head_we", rf_we, 1'b0);
    check("z_rd_busy", rd_busy, 1'b0);
    tick();
    mdu_valid = 1'b0;
    settle();
    check("z_popped_addr", rf_waddr, 5'd14);
    check("z_popped_data", rf_wdata, 32'hEE);
    tick();
    wb_en   = 1'b1;
    wb_addr = 5'd0;
    wb_data = 32'h3;
    settle();
    check("z_wb_we", rf_we, 1'b0);
    tick();

    // Starvation: FIFO head blocked by four writeback cycles
`ifdef REGFILE_ARB_STARVE_EN
    exp_stall = 1'b1;
`else
    exp_stall = 1'b0;
`endif
    issue(5'd15);
    wb_en     = 1'b1;
    wb_addr   = 5'd2;
    wb_data   = 32'h2;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd15;
    mdu_data  = 32'h5A;
    tick();
    mdu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("st_stall_low", stall_req, 1'b0);
      tick();
    end
    wb_en = 1'b0;
    settle();
    check("st_stall_req", stall_req, exp_stall);
    check("st_drain_data", rf_wdata, 32'h5A);
    tick();
    settle();
    check("st_stall_clr", stall_req, 1'b0);
    check("st_empty_we", rf_we, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
